// File: rtl/registrador_tempo_bcd.sv
// Keypad digit buffer forming MM:SS and handing it to the countdown timer.
// Define SATURA_SEGUNDOS_EN to clamp delivered seconds above 59 to 59.
module registrador_tempo_bcd #(
  parameter int MAX_DIGITOS = 4
) (
  input  logic       Clock,
  input  logic       Clear,
  input  logic       tecla_valida,
  input  logic [3:0] digito,
  input  logic       iniciar,
  input  logic       timer_ocupado,
  output logic [3:0] min_dez,
  output logic [3:0] min_uni,
  output logic [3:0] seg_dez,
  output logic [3:0] seg_uni,
  output logic [2:0] num_digitos,
  output logic       carregar,
  output logic       erro
);

  localparam logic [2:0] MAX = 3'(MAX_DIGITOS);

  typedef enum logic [2:0] {
    VAZIO, ENTRADA, CHEIO, ESPERA, ENTREGA
  } estado_t;

  estado_t     estado_q, estado_d;
  logic [15:0] buf_q, buf_d;
  logic [2:0]  num_q, num_d;
  logic        carregar_q, carregar_d;
  logic        erro_q, erro_d;
  logic        tecla_ant_q, tecla_ant_d;
  logic        ini_ant_q, ini_ant_d;
  logic        tecla_sub, ini_sub;
  logic        aceita, entra_entrega;

  always_comb begin
    estado_d      = estado_q;
    buf_d         = buf_q;
    num_d         = num_q;
    carregar_d    = 1'b0;
    erro_d        = 1'b0;
    tecla_ant_d   = tecla_valida;
    ini_ant_d     = iniciar;
    tecla_sub     = tecla_valida & ~tecla_ant_q;
    ini_sub       = iniciar & ~ini_ant_q;
    entra_entrega = 1'b0;
    aceita        = (estado_q == VAZIO)
                  | (estado_q == ENTRADA)
                  | (estado_q == CHEIO);

    // Digit is applied before the start request is evaluated.
    if (tecla_sub) begin
      if (!aceita || digito > 4'd9 || num_q == MAX) begin
        erro_d = 1'b1;
      end else begin
        buf_d = {buf_q[11:0], digito};
        num_d = num_q + 3'd1;
      end
    end

    unique case (estado_q)
      VAZIO, ENTRADA, CHEIO: begin
        if (num_d == 3'd0)     estado_d = VAZIO;
        else if (num_d == MAX) estado_d = CHEIO;
        else                   estado_d = ENTRADA;
        if (ini_sub && num_d != 3'd0) begin
          if (timer_ocupado) estado_d = ESPERA;
          else               entra_entrega = 1'b1;
        end
      end
      ESPERA: begin
        if (!timer_ocupado) entra_entrega = 1'b1;
      end
      ENTREGA: begin
        estado_d = VAZIO;
        buf_d    = '0;
        num_d    = '0;
      end
      default: begin
        estado_d = VAZIO;
      end
    endcase

    if (entra_entrega) begin
      estado_d   = ENTREGA;
      carregar_d = 1'b1;
`ifdef SATURA_SEGUNDOS_EN
      if (buf_d[7:0] > 8'h59) buf_d[7:0] = 8'h59;
`endif
    end
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      estado_q    <= VAZIO;
      buf_q       <= '0;
      num_q       <= '0;
      carregar_q  <= 1'b0;
      erro_q      <= 1'b0;
      tecla_ant_q <= 1'b0;
      ini_ant_q   <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      buf_q       <= buf_d;
      num_q       <= num_d;
      carregar_q  <= carregar_d;
      erro_q      <= erro_d;
      tecla_ant_q <= tecla_ant_d;
      ini_ant_q   <= ini_ant_d;
    end
  end

  assign min_dez     = buf_q[15:12];
  assign min_uni     = buf_q[11:8];
  assign seg_dez     = buf_q[7:4];
  assign seg_uni     = buf_q[3:0];
  assign num_digitos = num_q;
  assign carregar    = carregar_q;
  assign erro        = erro_q;

endmodule

// File: tb/tb_registrador_tempo_bcd.sv
// Bench for registrador_tempo_bcd: decimal-value model plus directed cases.
// Honours SATURA_SEGUNDOS_EN the same way the design does.
module tb_registrador_tempo_bcd;

  localparam int MAX = 4;

  logic       Clock = 1'b0;
  logic       Clear = 1'b1;
  logic       tecla_valida = 1'b0;
  logic [3:0] digito = 4'd0;
  logic       iniciar = 1'b0;
  logic       timer_ocupado = 1'b0;
  logic [3:0] min_dez, min_uni, seg_dez, seg_uni;
  logic [2:0] num_digitos;
  logic       carregar, erro;

  registrador_tempo_bcd #(.MAX_DIGITOS(MAX)) dut (
    .Clock(Clock), .Clear(Clear), .tecla_valida(tecla_valida),
    .digito(digito), .iniciar(iniciar), .timer_ocupado(timer_ocupado),
    .min_dez(min_dez), .min_uni(min_uni), .seg_dez(seg_dez),
    .seg_uni(seg_uni), .num_digitos(num_digitos),
    .carregar(carregar), .erro(erro)
  );

  always #5 Clock = ~Clock;

  int n_chk = 0;
  int n_pass = 0;

  // Model: the time is a decimal number, digits append as val*10+d.
  int val = 0, cnt = 0;
  bit waiting = 0, delivering = 0, pt = 0, pi = 0;
  bit m_carr = 0, m_err = 0, started = 0, tr, ir;

  task automatic deliver();
    delivering = 1;
    m_carr = 1;
`ifdef SATURA_SEGUNDOS_EN
    if (val % 100 > 59) val = val - (val % 100) + 59;
`endif
  endtask

  always @(posedge Clock) begin
    started = 1;
    if (Clear) begin
      val = 0; cnt = 0; waiting = 0; delivering = 0;
      pt = 0; pi = 0; m_carr = 0; m_err = 0;
    end else begin
      tr = tecla_valida && !pt;
      ir = iniciar && !pi;
      m_carr = 0;
      m_err = 0;
      if (delivering) begin
        val = 0; cnt = 0; delivering = 0;
        if (tr) m_err = 1;
      end else if (waiting) begin
        if (tr) m_err = 1;
        if (!timer_ocupado) begin
          waiting = 0;
          deliver();
        end
      end else begin
        if (tr) begin
          if (digito > 9 || cnt == MAX) m_err = 1;
          else begin
            val = (val * 10 + int'(digito)) % 10000;
            cnt++;
          end
        end
        if (ir && cnt > 0) begin
          if (timer_ocupado) waiting = 1;
          else deliver();
        end
      end
      pt = tecla_valida;
      pi = iniciar;
    end
  end

  function automatic logic [15:0] bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  logic [15:0] dig;
  assign dig = {min_dez, min_uni, seg_dez, seg_uni};

  int n_carr = 0, n_err = 0;
  logic [15:0] entregue = '0;

  always @(negedge Clock) begin
    if (started) begin
      n_chk++;
      if (dig === bcd(val) && num_digitos === 3'(cnt)
          && carregar === m_carr && erro === m_err) begin
        n_pass++;
      end else begin
        $display("FAIL model t=%0t dut=%h/%0d/%b/%b exp=%h/%0d/%b/%b",
          $time, dig, num_digitos, carregar, erro,
          bcd(val), cnt, m_carr, m_err);
      end
      if (carregar) begin
        n_carr++;
        entregue = dig;
      end
      if (erro) n_err++;
    end
  end

  task automatic check(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge Clock);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    tecla_valida = 1; digito = d; tick();
    tecla_valida = 0; tick();
  endtask

  task automatic start();
    iniciar = 1; tick();
    iniciar = 0; tick();
  endtask

  task automatic do_clear();
    Clear = 1; tick(2);
    Clear = 0; tick();
  endtask

  int c0, e0;

  initial begin
    tick(2);
    Clear = 0; tick();
    check("reset_digits", int'(dig), 0);
    check("reset_num", int'(num_digitos), 0);

    // 1) 1,2,3,0 then start, timer free
    press(1); press(2); press(3); press(0);
    check("t1_buffer", int'(dig), 'h1230);
    check("t1_num", int'(num_digitos), 4);
    c0 = n_carr;
    iniciar = 1; tick();
    check("t1_carregar", int'(carregar), 1);
    check("t1_hold", int'(dig), 'h1230);
    iniciar = 0; tick();
    check("t1_after_carr", int'(carregar), 0);
    check("t1_cleared", int'(dig), 0);
    check("t1_num0", int'(num_digitos), 0);
    check("t1_pulses", n_carr - c0, 1);

    // 2) held strobe counts once
    do_clear();
    tecla_valida = 1; digito = 7; tick(5);
    tecla_valida = 0; tick();
    check("t2_seg_uni", int'(seg_uni), 7);
    check("t2_num", int'(num_digitos), 1);

    // 3) invalid digit and overflow digit
    e0 = n_err;
    press(4'hB);
    check("t3_err_b", n_err - e0, 1);
    check("t3_buf_b", int'(dig), 'h0007);
    press(1); press(2); press(3);
    check("t3_full", int'(dig), 'h7123);
    e0 = n_err;
    press(5);
    check("t3_err_full", n_err - e0, 1);
    check("t3_buf_full", int'(dig), 'h7123);

    // 4) busy timer delays delivery
    do_clear();
    press(4); press(2);
    c0 = n_carr;
    timer_ocupado = 1;
    start();
    tick(10);
    check("t4_blocked", n_carr - c0, 0);
    timer_ocupado = 0; tick();
    check("t4_carregar", int'(carregar), 1);
    tick(3);
    check("t4_pulses", n_carr - c0, 1);
    check("t4_value", int'(entregue), 'h0042);

    // 5) clear while waiting, then start while empty
    do_clear();
    press(5); press(5);
    c0 = n_carr;
    timer_ocupado = 1;
    start(); tick(3);
    do_clear();
    timer_ocupado = 0; tick(3);
    check("t5_no_carr", n_carr - c0, 0);
    check("t5_zero", int'(dig), 0);
    e0 = n_err;
    start(); tick(2);
    check("t5_idle_carr", n_carr - c0, 0);
    check("t5_idle_err", n_err - e0, 0);

    // 6) seconds above 59
    press(0); press(1); press(9); press(9);
    start(); tick(2);
`ifdef SATURA_SEGUNDOS_EN
    check("t6_sat", int'(entregue), 'h0159);
`else
    check("t6_raw", int'(entregue), 'h0199);
`endif

    // 7) digit and start in the same cycle
    do_clear();
    press(3);
    c0 = n_carr;
    tecla_valida = 1; digito = 4; iniciar = 1; tick();
    tecla_valida = 0; iniciar = 0; tick(3);
    check("t7_value", int'(entregue), 'h0034);
    check("t7_pulses", n_carr - c0, 1);

    // 8) digit while waiting on busy timer
    do_clear();
    press(8);
    timer_ocupado = 1;
    start();
    e0 = n_err;
    press(6);
    check("t8_err", n_err - e0, 1);
    timer_ocupado = 0; tick(3);
    check("t8_value", int'(entregue), 'h0008);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
